lcd_ctrl: RTL

- Downstream consumer of the LSU's io_LCD output register; converts CPU-written LCD commands into HD44780-compatible bus cycles on the DE2 16x2 character LCD.
- Edge-detects a software "go" bit, latches RS/data, and sequences setup, EN pulse, hold and execution-delay timing with a counter-driven FSM.
- Holds one extra request in a one-deep pending buffer and reports busy/overflow status back for the LSU to map as a readable word.

---
 rtl/lcd_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/lcd_ctrl.sv
// HD44780 write sequencer for the DE2 16x2 LCD: turns go-bit edges on io_lcd into
// setup / EN pulse / hold / execution-wait bus cycles, with a one-deep pending slot.
module lcd_ctrl #(
  parameter int unsigned T_SETUP     = 3,
  parameter int unsigned T_EN        = 12,
  parameter int unsigned T_HOLD      = 2,
  parameter int unsigned T_EXEC      = 1850,
  parameter int unsigned T_EXEC_LONG = 76000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_lcd,
  output logic        lcd_on,
  output logic        lcd_en,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] lcd_status
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             go_prev_q, go_prev_d;
  logic             on_q, on_d;
  logic             act_rs_q, act_rs_d;
  logic [7:0]       act_data_q, act_data_d;
  logic             pend_valid_q, pend_valid_d;
  logic             pend_rs_q, pend_rs_d;
  logic [7:0]       pend_data_q, pend_data_d;
  logic             ovf_q, ovf_d;

  logic             req;
  logic             drop;
  logic             long_cmd;
  logic             unused_bits;

  assign unused_bits = ^{io_lcd[30:11], io_lcd[9]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      go_prev_q    <= 1'b0;
      on_q         <= 1'b0;
      act_rs_q     <= 1'b0;
      act_data_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_rs_q    <= 1'b0;
      pend_data_q  <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      go_prev_q    <= go_prev_d;
      on_q         <= on_d;
      act_rs_q     <= act_rs_d;
      act_data_q   <= act_data_d;
      pend_valid_q <= pend_valid_d;
      pend_rs_q    <= pend_rs_d;
      pend_data_q  <= pend_data_d;
      ovf_q        <= ovf_d;
    end
  end

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  assign long_cmd = !act_rs_q && (act_data_q[7:1] == 7'b0000000 || act_data_q[7:1] == 7'b0000001);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    go_prev_d    = io_lcd[10];
    on_d         = io_lcd[31];
    act_rs_d     = act_rs_q;
    act_data_d   = act_data_q;
    pend_valid_d = pend_valid_q;
    pend_rs_d    = pend_rs_q;
    pend_data_d  = pend_data_q;
    ovf_d        = ovf_q;
    drop         = 1'b0;
    req          = io_lcd[10] && !go_prev_q;

    unique case (state_q)
      S_IDLE: begin
        if (pend_valid_q) begin
          // Pending entry wins; a simultaneous new request refills the freed slot.
          act_rs_d     = pend_rs_q;
          act_data_d   = pend_data_q;
          pend_valid_d = req;
          if (req) begin
            pend_rs_d   = io_lcd[8];
            pend_data_d = io_lcd[7:0];
          end
          state_d = S_SETUP;
          cnt_d   = CNT_W'(T_SETUP - 1);
        end else if (req) begin
          act_rs_d   = io_lcd[8];
          act_data_d = io_lcd[7:0];
          state_d    = S_SETUP;
          cnt_d      = CNT_W'(T_SETUP - 1);
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = CNT_W'(T_EN - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = CNT_W'(T_HOLD - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_EXEC;
          cnt_d   = long_cmd ? CNT_W'(T_EXEC_LONG - 1) : CNT_W'(T_EXEC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (state_q != S_IDLE && req) begin
      if (!pend_valid_q) begin
        pend_valid_d = 1'b1;
        pend_rs_d    = io_lcd[8];
        pend_data_d  = io_lcd[7:0];
      end else begin
        drop = 1'b1;
      end
    end

    if (io_lcd[31] && !on_q) ovf_d = 1'b0;
    if (drop)                ovf_d = 1'b1;
  end

  always_comb begin
    lcd_en     = (state_q == S_PULSE);
    done       = (state_q == S_EXEC) && (cnt_q == '0);
    busy       = (state_q != S_IDLE) || pend_valid_q;
    lcd_on     = on_q;
    lcd_rs     = act_rs_q;
    lcd_data   = act_data_q;
    lcd_rw     = 1'b0;
    lcd_status = {29'b0, ovf_q, pend_valid_q, busy};
  end

endmodule
